can_rx: RTL and testbench

//  Serial receiver for the bridge's CAN-style frame; the inverse of the CAN transmit block.

---
 rtl/can_rx.sv | 104 ++++++++++
 tb/tb_can_rx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/can_rx.sv
// Serial CAN-style frame receiver: samples one bit per bit_en strobe, checks
// form and CRC, and holds accepted ID/CTRL/DATA for a valid/ack consumer.
module can_rx #(
   parameter int          ID_W      = 12,
   parameter int          CTRL_W    = 7,
   parameter int          DATA_W    = 64,
   parameter int          CRC_W     = 15,
   parameter logic [14:0] CRC_FIXED = 15'h2001,
   parameter int          EOF_W     = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              can_in,
   input  logic              bit_en,
   input  logic              rx_ack,
   output logic [ID_W-1:0]   rx_id,
   output logic [CTRL_W-1:0] rx_ctrl,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              err_pulse,
   output logic [2:0]        err_flags,
   output logic              busy
);

   localparam int FRAME_W  = 1 + ID_W + CTRL_W + DATA_W + CRC_W + 1 + 2 + EOF_W;
   localparam int R_W      = FRAME_W - 1;
   localparam int CTRL_LO  = ID_W;
   localparam int DATA_LO  = CTRL_LO + CTRL_W;
   localparam int CRC_LO   = DATA_LO + DATA_W;
   localparam int DELIM    = CRC_LO + CRC_W;
   localparam int EOF_LO   = DELIM + 1 + 2;
   localparam logic [6:0] LAST_CNT = 7'(FRAME_W - 1);

   typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

   state_t         state;
   logic [6:0]     bit_cnt;
   logic [R_W-1:0] r;

   logic crc_err;
   logic form_err;
   logic ovr_err;

   assign crc_err  = (r[CRC_LO +: CRC_W] != CRC_W'(CRC_FIXED));
   assign form_err = (r[DELIM] != 1'b1) || (r[EOF_LO +: EOF_W] != {EOF_W{1'b1}});
   // An ack in the CHECK cycle empties the buffer in time for the new frame.
   assign ovr_err  = rx_valid && !rx_ack;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         r         <= '0;
         rx_id     <= '0;
         rx_ctrl   <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         err_pulse <= 1'b0;
         err_flags <= '0;
         busy      <= 1'b0;
      end else begin
         err_pulse <= 1'b0;
         if (rx_valid && rx_ack)
            rx_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (bit_en && !can_in) begin
                  state   <= RECV;
                  bit_cnt <= 7'd1;
                  busy    <= 1'b1;
               end
            end
            RECV: begin
               if (bit_en) begin
                  r[bit_cnt - 7'd1] <= can_in;
                  bit_cnt           <= bit_cnt + 7'd1;
                  if (bit_cnt == LAST_CNT)
                     state <= CHECK;
               end
            end
            CHECK: begin
               state     <= IDLE;
               bit_cnt   <= '0;
               busy      <= 1'b0;
               err_flags <= {ovr_err, form_err, crc_err};
               if (ovr_err || form_err || crc_err) begin
                  err_pulse <= 1'b1;
               end else begin
                  rx_id    <= r[0 +: ID_W];
                  rx_ctrl  <= r[CTRL_LO +: CTRL_W];
                  rx_data  <= r[DATA_LO +: DATA_W];
                  rx_valid <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_can_rx.sv
// Directed bench for can_rx: hand-built frames, error injection, handshake,
// strobed sampling and mid-frame reset.
module tb_can_rx;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        can_in = 1'b1;
   logic        bit_en = 1'b0;
   logic        rx_ack = 1'b0;
   logic [11:0] rx_id;
   logic [6:0]  rx_ctrl;
   logic [63:0] rx_data;
   logic        rx_valid;
   logic        err_pulse;
   logic [2:0]  err_flags;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   can_rx dut (
      .clock     (clock),
      .reset     (reset),
      .can_in    (can_in),
      .bit_en    (bit_en),
      .rx_ack    (rx_ack),
      .rx_id     (rx_id),
      .rx_ctrl   (rx_ctrl),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .err_pulse (err_pulse),
      .err_flags (err_flags),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end else begin
         $display("ok   %s: %h", tag, obs);
      end
   endtask

   // Bit 0 is SOF; the ACK slot carries 2'b01 to show it is ignored.
   function automatic logic [106:0] mk(input logic [11:0] id, input logic [6:0] ctrl,
                                       input logic [63:0] data, input logic [14:0] crc,
                                       input logic delim, input logic [4:0] eof);
      return {eof, 2'b01, delim, crc, data, ctrl, id, 1'b0};
   endfunction

   // Non-strobe clocks drive the inverse of the coming bit as a glitch.
   task automatic send_frame(input logic [106:0] f, input int nbits, input int period);
      for (int i = 0; i < nbits; i++) begin
         for (int g = 1; g < period; g++) begin
            @(negedge clock);
            bit_en = 1'b0;
            can_in = ~f[i];
            @(posedge clock);
            #1;
         end
         @(negedge clock);
         bit_en = 1'b1;
         can_in = f[i];
         @(posedge clock);
         #1;
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         bit_en = 1'b1;
         can_in = 1'b1;
         @(posedge clock);
         #1;
      end
   endtask

   task automatic ack_cycle();
      @(negedge clock);
      bit_en = 1'b1;
      can_in = 1'b1;
      rx_ack = 1'b1;
      @(posedge clock);
      #1;
      @(negedge clock);
      rx_ack = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [106:0] fa;
      logic [106:0] fb;
      logic [106:0] fc;
      fa = mk(12'h5A3, 7'h20, 64'h0123456789ABCDEF, 15'h2001, 1'b1, 5'b11111);

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      check("rst_valid", 64'(rx_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      idle_cycles(2);
      check("rst_flags", 64'(err_flags), 64'd0);
      check("rst_id", 64'(rx_id), 64'd0);

      // 1: good frame, one bit per clock
      send_frame(fa, 107, 1);
      check("s1_busy_at_last", 64'(busy), 64'd1);
      check("s1_valid_at_last", 64'(rx_valid), 64'd0);
      idle_cycles(1);
      check("s1_valid", 64'(rx_valid), 64'd1);
      check("s1_id", 64'(rx_id), 64'h5A3);
      check("s1_ctrl", 64'(rx_ctrl), 64'h20);
      check("s1_data", rx_data, 64'h0123456789ABCDEF);
      check("s1_flags", 64'(err_flags), 64'd0);
      check("s1_pulse", 64'(err_pulse), 64'd0);
      check("s1_busy_after", 64'(busy), 64'd0);
      idle_cycles(1);
      check("s1_valid_held", 64'(rx_valid), 64'd1);
      ack_cycle();
      check("s1_ack_clears", 64'(rx_valid), 64'd0);

      // 2: bad CRC
      send_frame(mk(12'h5A3, 7'h20, 64'h0123456789ABCDEF, 15'h2002, 1'b1, 5'b11111), 107, 1);
      idle_cycles(1);
      check("s2_pulse", 64'(err_pulse), 64'd1);
      check("s2_flags", 64'(err_flags), 64'b001);
      check("s2_valid", 64'(rx_valid), 64'd0);
      idle_cycles(1);
      check("s2_pulse_one", 64'(err_pulse), 64'd0);
      check("s2_flags_kept", 64'(err_flags), 64'b001);

      // 3: form errors (second EOF bit low, then delimiter low)
      send_frame(mk(12'h5A3, 7'h20, 64'h0123456789ABCDEF, 15'h2001, 1'b1, 5'b11101), 107, 1);
      idle_cycles(1);
      check("s3a_flags", 64'(err_flags), 64'b010);
      check("s3a_pulse", 64'(err_pulse), 64'd1);
      check("s3a_valid", 64'(rx_valid), 64'd0);
      idle_cycles(1);
      send_frame(mk(12'h5A3, 7'h20, 64'h0123456789ABCDEF, 15'h2001, 1'b0, 5'b11111), 107, 1);
      idle_cycles(1);
      check("s3b_flags", 64'(err_flags), 64'b010);
      check("s3b_valid", 64'(rx_valid), 64'd0);

      // 4: overrun while frame 1 is held, then ack in the CHECK cycle of frame 3
      fb = mk(12'hABC, 7'h15, 64'hFEDCBA9876543210, 15'h2001, 1'b1, 5'b11111);
      fc = mk(12'h0F0, 7'h7F, 64'h8000000000000001, 15'h2001, 1'b1, 5'b11111);
      send_frame(fb, 107, 1);
      idle_cycles(1);
      check("s4_f1_valid", 64'(rx_valid), 64'd1);
      send_frame(fa, 107, 1);
      idle_cycles(1);
      check("s4_ovr_flags", 64'(err_flags), 64'b100);
      check("s4_ovr_pulse", 64'(err_pulse), 64'd1);
      check("s4_f1_id_kept", 64'(rx_id), 64'hABC);
      check("s4_f1_data_kept", rx_data, 64'hFEDCBA9876543210);
      check("s4_still_valid", 64'(rx_valid), 64'd1);
      send_frame(fc, 107, 1);
      @(negedge clock);
      rx_ack = 1'b1;
      @(posedge clock);
      #1;
      @(negedge clock);
      rx_ack = 1'b0;
      check("s4_f3_valid", 64'(rx_valid), 64'd1);
      check("s4_f3_flags", 64'(err_flags), 64'd0);
      check("s4_f3_id", 64'(rx_id), 64'h0F0);
      check("s4_f3_ctrl", 64'(rx_ctrl), 64'h7F);
      check("s4_f3_data", rx_data, 64'h8000000000000001);
      ack_cycle();

      // 5: one strobe in three with glitches between strobes
      send_frame(fa, 107, 3);
      idle_cycles(1);
      check("s5_valid", 64'(rx_valid), 64'd1);
      check("s5_id", 64'(rx_id), 64'h5A3);
      check("s5_ctrl", 64'(rx_ctrl), 64'h20);
      check("s5_data", rx_data, 64'h0123456789ABCDEF);
      check("s5_flags", 64'(err_flags), 64'd0);

      // 6: reset mid-frame with frame from scenario 5 still held
      send_frame(fb, 50, 1);
      check("s6_busy_mid", 64'(busy), 64'd1);
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("s6_rst_valid", 64'(rx_valid), 64'd0);
      check("s6_rst_busy", 64'(busy), 64'd0);
      check("s6_rst_data", rx_data, 64'd0);
      @(negedge clock);
      reset = 1'b0;
      idle_cycles(3);
      check("s6_no_pulse", 64'(err_pulse), 64'd0);
      check("s6_no_flags", 64'(err_flags), 64'd0);
      send_frame(fc, 107, 1);
      idle_cycles(1);
      check("s6_valid", 64'(rx_valid), 64'd1);
      check("s6_id", 64'(rx_id), 64'h0F0);
      check("s6_data", rx_data, 64'h8000000000000001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
